intr_timer_ctrl: RTL

//  Interrupt source stage feeding t_intr/e_intr of the CSR register file. Holds a 64-bit

---
 rtl/intr_timer_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/intr_timer_ctrl.sv
// Interrupt source stage: 64-bit mtime/mtimecmp timer with prescaler plus a synchronised
// external IRQ. Both are arbitrated into single-cycle pulses, one per mret-bounded window.
module intr_timer_ctrl #(
    parameter int unsigned DW       = 32,
    parameter int unsigned PRESCALE = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ext_irq_i,
    input  logic          is_mret_i,
    input  logic [2:0]    addr_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          t_intr_o,
    output logic          e_intr_o,
    output logic          busy_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {StIdle, StFireT, StFireE, StService} state_t;

    state_t      r_state;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [PW-1:0] r_pcnt;
    logic [1:0]  r_ctrl;
    logic [2:0]  r_sync;
    logic        r_ext_pend;
    logic        r_t_intr;
    logic        r_e_intr;
    logic        r_busy;

    logic        w_wr_mtime_lo;
    logic        w_wr_mtime_hi;
    logic        w_tick;
    logic        w_tmr_pend;
    logic        w_ext_edge;
    logic        w_clr_ext;
    logic [31:0] w_rdata;

    assign w_wr_mtime_lo = we_i && (addr_i == 3'd0);
    assign w_wr_mtime_hi = we_i && (addr_i == 3'd1);
    assign w_tick        = (r_pcnt == PMAX);
    assign w_tmr_pend    = r_ctrl[0] && (r_mtime >= r_mtimecmp);
    assign w_ext_edge    = r_sync[1] && !r_sync[2];
    assign w_clr_ext     = we_i && (addr_i == 3'd5) && wdata_i[1];

    // A software write to either mtime half beats the increment and restarts the prescaler.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtime <= 64'd0;
            r_pcnt  <= '0;
        end else if (w_wr_mtime_lo) begin
            r_mtime[31:0] <= wdata_i[31:0];
            r_pcnt        <= '0;
        end else if (w_wr_mtime_hi) begin
            r_mtime[63:32] <= wdata_i[31:0];
            r_pcnt         <= '0;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
            r_pcnt  <= '0;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtimecmp <= '1;
            r_ctrl     <= 2'b00;
        end else if (we_i) begin
            case (addr_i)
                3'd2:    r_mtimecmp[31:0]  <= wdata_i[31:0];
                3'd3:    r_mtimecmp[63:32] <= wdata_i[31:0];
                3'd4:    r_ctrl            <= wdata_i[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync     <= 3'b000;
            r_ext_pend <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], ext_irq_i};
            // A fresh edge wins over both the firing clear and a software clear.
            if (w_ext_edge && r_ctrl[1]) begin
                r_ext_pend <= 1'b1;
            end else if ((r_state == StFireE) || w_clr_ext) begin
                r_ext_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_t_intr <= 1'b0;
            r_e_intr <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_tmr_pend) begin
                        r_state  <= StFireT;
                        r_t_intr <= 1'b1;
                    end else if (r_ext_pend) begin
                        r_state  <= StFireE;
                        r_e_intr <= 1'b1;
                    end
                end
                StFireT: begin
                    r_state  <= StService;
                    r_t_intr <= 1'b0;
                    r_busy   <= 1'b1;
                end
                StFireE: begin
                    r_state  <= StService;
                    r_e_intr <= 1'b0;
                    r_busy   <= 1'b1;
                end
                StService: begin
                    if (is_mret_i) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_t_intr <= 1'b0;
                    r_e_intr <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (re_i) begin
            case (addr_i)
                3'd0:    w_rdata = r_mtime[31:0];
                3'd1:    w_rdata = r_mtime[63:32];
                3'd2:    w_rdata = r_mtimecmp[31:0];
                3'd3:    w_rdata = r_mtimecmp[63:32];
                3'd4:    w_rdata = {30'd0, r_ctrl};
                3'd5:    w_rdata = {29'd0, r_busy, r_ext_pend, w_tmr_pend};
                default: w_rdata = 32'd0;
            endcase
        end
    end

    assign rdata_o  = DW'(w_rdata);
    assign t_intr_o = r_t_intr;
    assign e_intr_o = r_e_intr;
    assign busy_o   = r_busy;

endmodule
